// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for load-use, taken branch and multi-cycle multiply
//   Inputs : clk, reset (async, active-high), rs_ID/rt_ID/uses_rt_ID (ID sources),
//            MemRead_EX/rt_EX (load in EX), branch_taken_EX, mult_start_EX
//   Outputs: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
//            ex_mem_bubble, mult_done, stall_cycles (only with HAZ_PERF_CNT_EN)
//   Macro  : HAZ_PERF_CNT_EN adds a saturating count of stalled (pc_write==0) cycles
module pipeline_hazard_ctrl #(
  parameter int MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  rt_EX,
  input  logic        branch_taken_EX,
  input  logic        mult_start_EX,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        mult_done
);
  localparam logic RUN       = 1'b0;
  localparam logic MULT_BUSY = 1'b1;
  logic       r_state;
  logic [3:0] r_cnt;
  logic       w_busy, w_last, w_branch, w_mult_stall, w_load_use, w_lu_stall;
  assign w_busy       = r_state == MULT_BUSY;
  assign w_last       = w_busy && r_cnt == 4'd1;
  assign w_branch     = !w_busy && branch_taken_EX;
  assign w_mult_stall = w_busy ? !w_last : (!branch_taken_EX && mult_start_EX);
  assign w_load_use   = MemRead_EX && rt_EX != 5'd0 &&
                        (rt_EX == rs_ID || (uses_rt_ID && rt_EX == rt_ID));
  assign w_lu_stall   = !w_busy && !branch_taken_EX && !mult_start_EX && w_load_use;
  // reset forces the "everything frozen and flushed" pattern regardless of inputs
  always_comb begin
    pc_write      = !reset && !w_mult_stall && !w_lu_stall;
    if_id_write   = !reset && !w_mult_stall && !w_lu_stall;
    id_ex_write   = !reset && !w_mult_stall;
    if_id_flush   = reset || w_branch;
    id_ex_flush   = reset || w_branch || w_lu_stall;
    ex_mem_bubble = !reset && w_mult_stall;
    mult_done     = !reset && w_last;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else if (w_busy) begin
      r_state <= w_last ? RUN : MULT_BUSY;
      r_cnt   <= r_cnt - 4'd1;
    end else if (!branch_taken_EX && mult_start_EX) begin
      r_state <= MULT_BUSY;
      r_cnt   <= 4'(MULT_CYCLES - 1);
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_cycles <= 32'd0;
    else if (!pc_write && r_stall_cycles != 32'hFFFF_FFFF) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_ID = '0, rt_ID = '0, rt_EX = '0;
  logic       uses_rt_ID = 1'b0, MemRead_EX = 1'b0, branch_taken_EX = 1'b0, mult_start_EX = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, mult_done;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif
  int errors = 0;
  int checks = 0;
  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, mult_done}
  localparam logic [6:0] DEF  = 7'b1101000;
  localparam logic [6:0] RST  = 7'b0010100;
  localparam logic [6:0] LU   = 7'b0001100;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] MS   = 7'b0000010;
  localparam logic [6:0] DONE = 7'b1101001;
  typedef struct { string tag; logic [6:0] exp; } exp_t;
  exp_t sb[$];
  pipeline_hazard_ctrl #(.MULT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .branch_taken_EX(branch_taken_EX),
    .mult_start_EX(mult_start_EX),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .mult_done(mult_done)
  );
  always #5 clk = ~clk;
  task automatic pop_check();
    exp_t e;
    logic [6:0] obs;
    e = sb.pop_front();
    obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, mult_done};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask
  task automatic drive(input logic mr, input logic [4:0] rte, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic br, input logic ms);
    MemRead_EX = mr; rt_EX = rte; rs_ID = rs; rt_ID = rt; uses_rt_ID = urt;
    branch_taken_EX = br; mult_start_EX = ms;
  endtask
  task automatic cyc(input string tag, input logic [6:0] exp);
    sb.push_back('{tag, exp});
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("reset_idle", RST);
    drive(1, 5, 5, 0, 0, 1, 1);
    cyc("reset_ignores_inputs", RST);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("idle_default", DEF);
    drive(1, 5, 5, 0, 0, 0, 0);
    cyc("loaduse_rs", LU);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("after_loaduse", DEF);
    drive(1, 7, 3, 7, 1, 0, 0);
    cyc("loaduse_rt", LU);
    drive(1, 7, 3, 7, 0, 0, 0);
    cyc("rt_not_used", DEF);
    drive(1, 0, 0, 0, 1, 0, 0);
    cyc("zero_reg", DEF);
    drive(0, 5, 5, 5, 1, 0, 0);
    cyc("no_memread", DEF);
    drive(1, 5, 5, 0, 0, 1, 0);
    cyc("branch_over_loaduse", BR);
    drive(0, 0, 0, 0, 0, 1, 1);
    cyc("branch_over_mult", BR);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("no_mult_after_branch", DEF);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc("mult_T0", MS);
    drive(0, 0, 0, 0, 0, 1, 0);
    cyc("mult_T1_branch_ignored", MS);
    drive(1, 5, 5, 0, 0, 0, 1);
    cyc("mult_T2", MS);
    drive(1, 5, 5, 0, 0, 0, 1);
    cyc("mult_done_T3", DONE);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("mult_back_to_run", DEF);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc("b2b_first_T0", MS);
    cyc("b2b_first_T1", MS);
    cyc("b2b_first_T2", MS);
    cyc("b2b_first_done", DONE);
    cyc("b2b_second_T0", MS);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("b2b_second_T1", MS);
    cyc("b2b_second_T2", MS);
    cyc("b2b_second_done", DONE);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc("abort_T0", MS);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("abort_T1", MS);
    reset = 1'b1;
    #1;
    sb.push_back('{"async_reset", RST});
    pop_check();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post_reset_run", DEF);
    cyc("no_stale_done", DEF);
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc("restart_T0", MS);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("restart_T1", MS);
    cyc("restart_T2", MS);
    cyc("restart_done", DONE);
    cyc("restart_run", DEF);
    drive(1, 9, 9, 0, 0, 0, 0);
    cyc("final_loaduse", LU);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc("final_idle", DEF);
`ifdef HAZ_PERF_CNT_EN
    checks++;
    assert (stall_cycles === 32'd4) else begin
      errors++;
      $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, 4);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
